// File: rtl/code_loader_pkg.sv
// Shared definitions for the BPF code loader: code RAM depth, stream beat
// width, counter widths and the loader FSM state encoding.
package code_loader_pkg;

  // Instruction capacity of the code RAM
  localparam int DEPTH  = 256;
  // Width of one program-stream beat; an instruction is two beats
  localparam int BEAT_W = 32;
  // Instruction counter covers 0..DEPTH-1
  localparam int CNT_W  = 8;
  // Program length covers 0..DEPTH
  localparam int LEN_W  = 9;

  typedef enum logic [1:0] {
    ST_HI    = 2'd0,
    ST_LO    = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/code_loader.sv
// code_loader
// Receives a program as a stream of 32-bit beats (high word first, then low
// word) and writes each assembled 64-bit instruction into the filter CPU's
// code RAM. Tracks program completion, length and the two load errors.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast   program stream
//   cpu_idle            filter CPU idle; gates the first beat of a load
//   wr_addr/wr_data/wr_en   code RAM write port (registered)
//   loading             load in progress
//   prog_valid          complete program resident
//   prog_len            instruction count of the last good program
//   err_odd             sticky: program ended on a high-word beat
//   err_overflow        sticky: program longer than DEPTH instructions
//
// state    | meaning
// ST_HI    | expecting the high word [63:32] of the next instruction
// ST_LO    | expecting the low word [31:0]; handshake triggers the write
// ST_DRAIN | RAM full; discard beats up to tlast, then flag overflow
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BEAT_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  cpu_idle,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  loading,
  output logic                  prog_valid,
  output logic [LEN_W-1:0]      prog_len,
  output logic                  err_odd,
  output logic                  err_overflow
);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BEAT_W-1:0]       hi_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_en_q;
  logic                    loading_q;
  logic                    prog_valid_q;
  logic [LEN_W-1:0]        prog_len_q;
  logic                    err_odd_q;
  logic                    err_ovf_q;
  logic                    hs;
  logic                    cnt_full;

  // A new program may only start while the CPU is idle; once loading is set
  // the stream is never stalled, whatever cpu_idle does.
  assign s_axis_tready = (state_q == ST_HI) ? (cpu_idle | loading_q) : 1'b1;
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign cnt_full      = (cnt_q == CNT_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HI;
      cnt_q        <= '0;
      hi_q         <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      loading_q    <= 1'b0;
      prog_valid_q <= 1'b0;
      prog_len_q   <= '0;
      err_odd_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (hs) begin
        case (state_q)
          ST_HI: begin
            hi_q <= s_axis_tdata;
            // First beat of a program: forget the previous program's status
            if (!loading_q) begin
              prog_valid_q <= 1'b0;
              err_odd_q    <= 1'b0;
              err_ovf_q    <= 1'b0;
            end
            if (s_axis_tlast) begin
              // Program ended on a dangling high word; nothing is written
              err_odd_q <= 1'b1;
              loading_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= ST_HI;
            end else begin
              loading_q <= 1'b1;
              state_q   <= ST_LO;
            end
          end

          ST_LO: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= ADDR_WIDTH'(cnt_q);
            wr_data_q <= DATA_WIDTH'({hi_q, s_axis_tdata});
            if (s_axis_tlast) begin
              prog_valid_q <= 1'b1;
              prog_len_q   <= LEN_W'(cnt_q) + LEN_W'(1);
              cnt_q        <= '0;
              loading_q    <= 1'b0;
              state_q      <= ST_HI;
            end else if (!cnt_full) begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_HI;
            end else begin
              // Last RAM slot just filled; counter is held, not wrapped
              state_q <= ST_DRAIN;
            end
          end

          ST_DRAIN: begin
            if (s_axis_tlast) begin
              err_ovf_q <= 1'b1;
              loading_q <= 1'b0;
              cnt_q     <= '0;
              state_q   <= ST_HI;
            end
          end

          default: begin
            state_q <= ST_HI;
          end
        endcase
      end
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_en        = wr_en_q;
  assign loading      = loading_q;
  assign prog_valid   = prog_valid_q;
  assign prog_len     = prog_len_q;
  assign err_odd      = err_odd_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        cpu_idle;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_en;
  logic        loading;
  logic        prog_valid;
  logic [8:0]  prog_len;
  logic        err_odd;
  logic        err_overflow;

  code_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .cpu_idle     (cpu_idle),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .loading      (loading),
    .prog_valid   (prog_valid),
    .prog_len     (prog_len),
    .err_odd      (err_odd),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] beats_buf [0:599];
  logic [73:0] wq [$];

  // Capture every RAM write as {addr, data}
  always @(negedge clk) begin
    if (rst_n && wr_en) wq.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send beats_buf[0..n-1]; tlast on the final beat when with_last is set.
  // rnd randomizes tvalid gaps and cpu_idle each cycle.
  task automatic send_prog(input int n, input bit rnd, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int  waited = 0;
      bit  done   = 0;
      while (!done) begin
        @(negedge clk);
        s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        cpu_idle      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_axis_tdata  = beats_buf[i];
        s_axis_tlast  = with_last && (i == n - 1);
        #1;
        if (s_axis_tvalid && s_axis_tready) done = 1;
        else begin
          waited++;
          if (waited > 2000) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: beat %0d never accepted", i);
            s_axis_tvalid = 1'b0;
            return;
          end
        end
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cpu_idle      = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) beats_buf[i] = $urandom;
  endtask

  // Writes expected: one per complete beat pair, at most 256
  task automatic check_writes(input string name, input int n);
    int w;
    int bad;
    int first;
    logic [73:0] exp_e;
    w     = (n / 2 > 256) ? 256 : n / 2;
    bad   = 0;
    first = -1;
    chk({name, "_wcount"}, 64'(wq.size()), 64'(w));
    for (int j = 0; j < w && j < wq.size(); j++) begin
      exp_e = {10'(j), beats_buf[2*j], beats_buf[2*j+1]};
      if (wq[j] !== exp_e) begin
        bad++;
        if (first < 0) first = j;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      exp_e = {10'(first), beats_buf[2*first], beats_buf[2*first+1]};
      $display("FAIL %s_wdata: %0d bad writes, first #%0d got %0h expected %0h",
               name, bad, first, wq[first], exp_e);
    end
    wq.delete();
  endtask

  task automatic check_flags(input string name, input bit v, input int len,
                             input bit odd, input bit ovf);
    chk({name, "_valid"},   64'(prog_valid),   64'(v));
    chk({name, "_len"},     64'(prog_len),     64'(len));
    chk({name, "_odd"},     64'(err_odd),      64'(odd));
    chk({name, "_ovf"},     64'(err_overflow), 64'(ovf));
    chk({name, "_loading"}, 64'(loading),      64'(1'b0));
  endtask

  typedef struct {
    int nbeats;
    bit rnd;
    bit exp_valid;
    int exp_len;
    bit exp_odd;
    bit exp_ovf;
  } vec_t;

  vec_t tbl [8];

  // Reference: classify a program purely by its beat count
  int m_len;

  task automatic model(input int n, output bit v, output bit odd, output bit ovf);
    v = 0; odd = 0; ovf = 0;
    if (n > 512) ovf = 1;
    else if (n % 2 == 1) odd = 1;
    else begin
      v     = 1;
      m_len = n / 2;
    end
  endtask

  initial begin
    bit v, odd, ovf;
    int n, stuck;

    tbl[0] = '{32,  0, 1, 16,  0, 0};
    tbl[1] = '{3,   1, 0, 16,  1, 0};
    tbl[2] = '{4,   1, 1, 2,   0, 0};
    tbl[3] = '{1,   0, 0, 2,   1, 0};
    tbl[4] = '{516, 0, 0, 2,   0, 1};
    tbl[5] = '{512, 0, 1, 256, 0, 0};
    tbl[6] = '{513, 1, 0, 256, 0, 1};
    tbl[7] = '{2,   1, 1, 1,   0, 0};

    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    cpu_idle = 1'b1;
    #1;
    chk("rst_wr_en",   64'(wr_en),   0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_wr_data", wr_data,      0);
    check_flags("rst", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      string nm;
      nm = $sformatf("tbl%0d", t);
      fill_random(tbl[t].nbeats);
      send_prog(tbl[t].nbeats, tbl[t].rnd, 1'b1);
      check_flags(nm, tbl[t].exp_valid, tbl[t].exp_len, tbl[t].exp_odd, tbl[t].exp_ovf);
      check_writes(nm, tbl[t].nbeats);
    end

    m_len = 1;
    for (int r = 0; r < 25; r++) begin
      string nm;
      nm = $sformatf("rnd%0d", r);
      n = (r == 12) ? $urandom_range(510, 516) : $urandom_range(1, 24);
      fill_random(n);
      send_prog(n, 1'b1, 1'b1);
      model(n, v, odd, ovf);
      check_flags(nm, v, m_len, odd, ovf);
      check_writes(nm, n);
    end

    // Known instruction; cpu_idle dropped mid-instruction must not stall
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'h0028_0000;
    s_axis_tlast  = 1'b0;
    cpu_idle      = 1'b1;
    @(negedge clk);
    cpu_idle      = 1'b0;
    s_axis_tdata  = 32'h0000_000C;
    s_axis_tlast  = 1'b1;
    #1;
    chk("busy_tready", 64'(s_axis_tready), 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cpu_idle      = 1'b1;
    @(negedge clk);
    chk("known_wcount", 64'(wq.size()), 1);
    if (wq.size() > 0) chk("known_wdata", {wq[0][73:64], 54'd0} | {54'd0, wq[0][73:64]}, 0);
    if (wq.size() > 0) chk("known_data", wq[0][63:0], 64'h0028_0000_0000_000C);
    check_flags("known", 1, 1, 0, 0);
    wq.delete();

    // CPU busy and no load in progress: stream held off
    fill_random(2);
    @(negedge clk);
    cpu_idle      = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = beats_buf[0];
    stuck = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (s_axis_tready) stuck++;
    end
    chk("idle_block", 64'(stuck), 0);
    chk("idle_nowrite", 64'(wq.size()), 0);
    chk("idle_loading", 64'(loading), 0);
    send_prog(2, 1'b0, 1'b1);
    check_flags("idle", 1, 1, 0, 0);
    check_writes("idle", 2);

    // Reset in the middle of a load
    fill_random(10);
    send_prog(10, 1'b0, 1'b0);
    chk("midrst_pre_wcount", 64'(wq.size()), 5);
    chk("midrst_pre_loading", 64'(loading), 1);
    wq.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en",   64'(wr_en),   0);
    chk("midrst_wr_addr", 64'(wr_addr), 0);
    chk("midrst_wr_data", wr_data,      0);
    check_flags("midrst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_random(4);
    send_prog(4, 1'b0, 1'b1);
    check_flags("postrst", 1, 2, 0, 0);
    check_writes("postrst", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
